// File: rtl/lsu_store_buffer_pkg.sv
// lsu_pkg: shared types, funct3 codes and helpers for the store-buffered load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {
    BYTE              = 3'b000,
    HALFWORD          = 3'b001,
    WORD              = 3'b010,
    BYTE_UNSIGNED     = 3'b011,
    HALFWORD_UNSIGNED = 3'b100
  } mem_acc_mode_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'd0,
    EXC_ST_MISALIGN = 2'd1,
    EXC_ILLEGAL     = 2'd2
  } exc_cause_e;
  // widest address a buffered store can hold
  localparam int SB_ADDR_W = 32;
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    mem_acc_mode_e        mode;
    logic [31:0]          wdata;
  } sb_entry_t;
  // log2 of the access size in bytes
  function automatic logic [1:0] mode_size(input mem_acc_mode_e m);
    return (m == WORD) ? 2'd2 : (m == HALFWORD || m == HALFWORD_UNSIGNED) ? 2'd1 : 2'd0;
  endfunction
  // sign/zero extension of right-aligned data, matching what the memory returns
  function automatic logic [31:0] ext_load(input logic [31:0] d, input mem_acc_mode_e m);
    return m == BYTE ? {{24{d[7]}}, d[7:0]} :
           m == HALFWORD ? {{16{d[15]}}, d[15:0]} :
           m == BYTE_UNSIGNED ? {24'd0, d[7:0]} :
           m == HALFWORD_UNSIGNED ? {16'd0, d[15:0]} : d;
  endfunction
endpackage

// File: rtl/lsu_store_buffer_sb_fifo.sv
// lsu_sb_fifo: store-buffer FIFO exposing every entry oldest-first with valid bits
module lsu_sb_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  sb_entry_t  din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output sb_entry_t  ent [DEPTH],
  output logic [DEPTH-1:0] vld
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent[i] = mem[rd_ptr + PW'(i)];
    assign vld[i] = (PW+1)'(i) < count;
  end
  // pointers wrap on their own because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: RISC-V load/store unit with a store buffer draining into a single-port memory
// Define LSU_STORE_FWD_EN to answer exact addr/width matches from the youngest buffered store.
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              dm_rd_en,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [2:0]        dm_mem_acc_mode,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
`ifdef LSU_STORE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  sb_entry_t ent [SB_DEPTH];
  sb_entry_t head, fwd_ent, push_ent;
  logic [SB_DEPTH-1:0] vld;
  mem_acc_mode_e mode;
  logic full, empty, is_ld, is_st, f3_ok, illegal, misaligned, exc;
  logic legal_ld, legal_st, hazard, fwd, fire, ld_fire, ld_mem, pop;
  assign is_ld = req_is_load && !req_is_store;
  assign is_st = req_is_store && !req_is_load;
  // funct3 to memory access mode; undefined codes are caught by f3_ok
  always_comb begin
    case (req_funct3)
      F3_H:    mode = HALFWORD;
      F3_W:    mode = WORD;
      F3_BU:   mode = BYTE_UNSIGNED;
      F3_HU:   mode = HALFWORD_UNSIGNED;
      default: mode = BYTE;
    endcase
  end
  assign f3_ok = is_ld ? req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} : req_funct3 inside {F3_B, F3_H, F3_W};
  assign illegal = (req_is_load && req_is_store) || ((is_ld || is_st) && !f3_ok);
  assign misaligned = !illegal && (is_ld || is_st) &&
                      ((mode_size(mode) == 2'd1 && req_addr[0]) || (mode_size(mode) == 2'd2 && req_addr[1:0] != 2'b00));
  assign exc = illegal || misaligned;
  assign legal_ld = is_ld && !exc;
  assign legal_st = is_st && !exc;
  // word-granular conflict scan; the last match in age order is the youngest store
  always_comb begin
    hazard = 1'b0;
    fwd_ent = ent[0];
    for (int i = 0; i < SB_DEPTH; i++)
      if (vld[i] && ent[i].addr[ADDR_W-1:2] == req_addr[ADDR_W-1:2]) begin
        hazard = 1'b1;
        fwd_ent = ent[i];
      end
  end
  assign fwd = FWD_EN && hazard && fwd_ent.addr == SB_ADDR_W'(req_addr) && mode_size(fwd_ent.mode) == mode_size(mode);
  assign req_ready = !rst && ((exc || !(is_ld || is_st)) ? 1'b1 : is_st ? !full : !full && (!hazard || fwd));
  assign fire = req_valid && req_ready;
  assign ld_fire = fire && legal_ld;
  assign ld_mem = ld_fire && !fwd;
  assign pop = !rst && !ld_mem && !empty;
  assign head = ent[0];
  assign push_ent = '{addr: SB_ADDR_W'(req_addr), mode: mode, wdata: req_wdata};
  assign dm_rd_en = ld_mem;
  assign dm_wr_en = pop;
  assign dm_addr = ld_mem ? req_addr : ADDR_W'(head.addr);
  assign dm_mem_acc_mode = ld_mem ? mode : head.mode;
  assign dm_wdata = head.wdata;
  lsu_sb_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(fire && legal_st), .din(push_ent), .pop(pop),
    .full(full), .empty(empty), .ent(ent), .vld(vld)
  );
  // load data and exception pulses land the cycle after the request fires
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      exc_valid <= 1'b0;
      exc_cause <= '0;
      exc_addr <= '0;
    end else begin
      resp_valid <= ld_fire;
      exc_valid <= fire && exc;
      if (ld_fire) resp_rdata <= fwd ? ext_load(fwd_ent.wdata, mode) : dm_rdata;
      if (fire && exc) begin
        exc_cause <= illegal ? EXC_ILLEGAL : is_ld ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        exc_addr <= req_addr;
      end
    end
  end
endmodule

// File: tb/tb_lsu_store_buffer.sv
// tb_lsu_store_buffer: queue-based reference model with per-cycle compare, directed pins and random traffic
module tb_lsu_store_buffer;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_is_load = 0, req_is_store = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, exc_valid, dm_rd_en, dm_wr_en;
  logic [31:0] resp_rdata, exc_addr, dm_addr, dm_wdata, dm_rdata;
  logic [1:0] exc_cause;
  logic [2:0] dm_mem_acc_mode;
  always #5 clk = ~clk;
  lsu_store_buffer #(.SB_DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_mem_acc_mode(dm_mem_acc_mode), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  bit mem_init = 0, ref_init = 0;
  int compared = 0, mismatched = 0, wr_pulses = 0, rd_pulses = 0;
  typedef struct {logic [31:0] addr; logic [2:0] mode; logic [31:0] data;} st_t;
  st_t q[$];
  bit p_resp = 0, p_exc = 0;
  logic [31:0] p_data = 0, p_addr = 0;
  logic [1:0] p_cause = 0;
`ifdef LSU_STORE_FWD_EN
  localparam bit FWD = 1;
`else
  localparam bit FWD = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] m);
    return (m == 0 || m == 3) ? 1 : (m == 1 || m == 4) ? 2 : 4;
  endfunction
  function automatic logic [31:0] raw_of(input logic [31:0] w, input int n);
    return n == 1 ? {24'd0, w[31:24]} : n == 2 ? {16'd0, w[31:16]} : w;
  endfunction
  function automatic logic [31:0] ext(input logic [31:0] r, input logic [2:0] m);
    case (m)
      3'd0: return {{24{r[7]}}, r[7:0]};
      3'd1: return {{16{r[15]}}, r[15:0]};
      3'd3: return {24'd0, r[7:0]};
      3'd4: return {16'd0, r[15:0]};
      default: return r;
    endcase
  endfunction
  function automatic logic [31:0] word_at(input logic [7:0] a, input bit use_ref);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = use_ref ? ref_mem[8'(a + i)] : mem[8'(a + i)];
    return w;
  endfunction
  // kind: 0 no-op, 1 legal load, 2 legal store, 3 exception
  function automatic void decode(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 output int kind, output logic [2:0] m, output logic [1:0] cause);
    bit ok;
    kind = 0; m = 0; cause = 0; ok = 1;
    if (ld && st) begin kind = 3; cause = 2; return; end
    if (!ld && !st) return;
    if (ld) begin
      case (f3)
        3'd0: m = 0;
        3'd1: m = 1;
        3'd2: m = 2;
        3'd4: m = 3;
        3'd5: m = 4;
        default: ok = 0;
      endcase
    end else begin
      ok = f3 <= 3'd2;
      m = f3;
    end
    if (!ok) begin kind = 3; cause = 2; return; end
    if (a % nbytes(m) != 0) begin kind = 3; cause = ld ? 2'd0 : 2'd1; return; end
    kind = ld ? 1 : 2;
  endfunction

  // data memory: async read, sync write, big-endian, performs the load extension
  assign dm_rdata = ext(raw_of(word_at(dm_addr[7:0], 0), nbytes(dm_mem_acc_mode)), dm_mem_acc_mode);
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1;
    end else if (dm_wr_en) begin
      wr_pulses++;
      for (int i = 0; i < nbytes(dm_mem_acc_mode); i++)
        mem[8'(dm_addr[7:0] + i)] <= dm_wdata[8*(nbytes(dm_mem_acc_mode)-1-i) +: 8];
    end
    if (dm_rd_en) rd_pulses++;
  end

  // reference model and per-cycle compare
  always @(negedge clk) begin
    int kind, yi, n;
    logic [2:0] m;
    logic [1:0] cause;
    bit haz, fwd, rdy, fire, erd, ewr;
    if (!ref_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
      ref_init = 1;
    end
    chk("resp_valid", resp_valid, p_resp);
    if (p_resp) chk("resp_rdata", resp_rdata, p_data);
    chk("exc_valid", exc_valid, p_exc);
    if (p_exc) begin
      chk("exc_cause", exc_cause, p_cause);
      chk("exc_addr", exc_addr, p_addr);
    end
    if (rst) begin
      chk("ready_in_rst", req_ready, 0);
      chk("rd_in_rst", dm_rd_en, 0);
      chk("wr_in_rst", dm_wr_en, 0);
      q.delete();
      p_resp = 0;
      p_exc = 0;
    end else begin
      decode(req_is_load, req_is_store, req_funct3, req_addr, kind, m, cause);
      haz = 0; fwd = 0; yi = 0;
      if (kind == 1)
        for (int i = 0; i < q.size(); i++)
          if (q[i].addr[31:2] == req_addr[31:2]) begin haz = 1; yi = i; end
      if (FWD && haz) fwd = q[yi].addr == req_addr && nbytes(q[yi].mode) == nbytes(m);
      rdy = kind == 1 ? (q.size() < DEPTH && (!haz || fwd)) : kind == 2 ? q.size() < DEPTH : 1;
      fire = req_valid && rdy;
      erd = fire && kind == 1 && !fwd;
      ewr = !erd && q.size() != 0;
      chk("req_ready", req_ready, rdy);
      chk("dm_rd_en", dm_rd_en, erd);
      chk("dm_wr_en", dm_wr_en, ewr);
      if (erd) begin
        chk("rd_addr", dm_addr, req_addr);
        chk("rd_mode", dm_mem_acc_mode, m);
      end
      if (ewr) begin
        chk("wr_addr", dm_addr, q[0].addr);
        chk("wr_mode", dm_mem_acc_mode, q[0].mode);
        chk("wr_data", dm_wdata, q[0].data);
      end
      p_resp = fire && kind == 1;
      if (p_resp) p_data = fwd ? ext(q[yi].data, m) : ext(raw_of(word_at(req_addr[7:0], 1), nbytes(m)), m);
      p_exc = fire && kind == 3;
      if (p_exc) begin p_cause = cause; p_addr = req_addr; end
      if (ewr) begin
        n = nbytes(q[0].mode);
        for (int i = 0; i < n; i++) ref_mem[8'(q[0].addr[7:0] + i)] = q[0].data[8*(n-1-i) +: 8];
        void'(q.pop_front());
      end
      if (fire && kind == 2) q.push_back('{addr: req_addr, mode: m, data: req_wdata});
    end
  end

  // present a request at posedge+1 and hold it until it fires; returns the stall count
  task automatic send(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, output int waits);
    req_valid = 1; req_is_load = ld; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = d;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: req_ready got 0 expected 1 for addr %h", a);
    end
    @(posedge clk); #1;
    req_valid = 0; req_is_load = 0; req_is_store = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    int w;
    send(1, 0, f3, a, 0, w);
    @(negedge clk);
    chk({name, "_valid"}, resp_valid, 1);
    chk({name, "_data"}, resp_rdata, exp);
    @(posedge clk); #1;
  endtask
  task automatic exc_chk(input string name, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [1:0] cause);
    int w, r0;
    r0 = rd_pulses;
    send(ld, st, f3, a, 32'hDEAD_BEEF, w);
    @(negedge clk);
    chk({name, "_valid"}, exc_valid, 1);
    chk({name, "_cause"}, exc_cause, cause);
    chk({name, "_addr"}, exc_addr, a);
    @(negedge clk);
    chk({name, "_pulse_end"}, exc_valid, 0);
    chk({name, "_no_read"}, rd_pulses - r0, 0);
    @(posedge clk); #1;
  endtask
  task automatic reset_values(input string name);
    @(negedge clk);
    chk({name, "_resp_valid"}, resp_valid, 0);
    chk({name, "_resp_rdata"}, resp_rdata, 0);
    chk({name, "_exc_valid"}, exc_valid, 0);
    chk({name, "_exc_cause"}, exc_cause, 0);
    chk({name, "_exc_addr"}, exc_addr, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w, w0;
    logic [31:0] saved;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    reset_values("post_reset");
    // SW then LBU of the second byte (big-endian)
    w0 = wr_pulses;
    send(0, 1, 3'b010, 8, 32'h1122_3344, w);
    idle(2);
    chk("sw_drain_pulse", wr_pulses - w0, 1);
    load_chk("lbu_9", 3'b100, 9, 32'h0000_0022);
    // SB then signed and unsigned byte loads
    send(0, 1, 3'b000, 12, 32'h0000_0080, w);
    idle(2);
    load_chk("lb_12", 3'b000, 12, 32'hFFFF_FF80);
    load_chk("lbu_12", 3'b100, 12, 32'h0000_0080);
    load_chk("lhu_8", 3'b101, 8, 32'h0000_1122);
    // store followed immediately by a load of the same word
    send(0, 1, 3'b010, 16, 32'hCAFE_F00D, w);
    send(1, 0, 3'b010, 16, 0, w);
    chk("lw_hazard_waits", w, FWD ? 0 : 1);
    @(negedge clk);
    chk("lw_hazard_valid", resp_valid, 1);
    chk("lw_hazard_data", resp_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    // exceptions
    exc_chk("lw_mis", 1, 0, 3'b010, 6, 2'd0);
    exc_chk("sh_mis", 0, 1, 3'b001, 3, 2'd1);
    exc_chk("ld_f3_ill", 1, 0, 3'b011, 0, 2'd2);
    exc_chk("both_ill", 1, 1, 3'b010, 32'h21, 2'd2);
    exc_chk("lhu_mis", 1, 0, 3'b101, 5, 2'd0);
    // stores interleaved with a load stream to other words
    for (int i = 0; i < 4; i++) begin
      send(0, 1, 3'b010, 32 + 4 * i, 32'hA0A0_0000 + i, w);
      send(1, 0, 3'b010, 48 + 4 * (i % 2), 0, w);
      send(1, 0, 3'b000, 57 + i, 0, w);
    end
    idle(3);
    for (int i = 0; i < 4; i++) chk("stream_word", word_at(8'(32 + 4 * i), 0), 32'hA0A0_0000 + i);
    // reset with a store still buffered discards it
    send(0, 1, 3'b010, 20, 32'h5555_AAAA, w);
    send(0, 1, 3'b010, 24, 32'h1234_5678, w);
    rst = 1;
    w0 = wr_pulses;
    saved = word_at(24, 0);
    @(posedge clk); #1;
    rst = 0;
    reset_values("mid_reset");
    idle(2);
    chk("rst_no_drain", wr_pulses - w0, 0);
    chk("rst_word_kept", word_at(24, 0), saved);
    chk("rst_prior_word", word_at(20, 0), 32'h5555_AAAA);
    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      req_valid = $urandom_range(0, 3) != 0;
      req_is_load = r < 4 || r == 8;
      req_is_store = (r >= 4 && r < 8) || r == 8;
      req_funct3 = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      req_addr = 32'($urandom_range(0, 7) * 4 + ($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0));
      req_wdata = $urandom;
      rst = $urandom_range(0, 299) == 0;
      @(posedge clk); #1;
    end
    req_valid = 0; req_is_load = 0; req_is_store = 0; rst = 0;
    idle(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
